// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// default operand widths.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_DIV_WIDTH = 8;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, compare against the divisor, conditionally subtract.
module div_step #(
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0]     quo_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [DIV_WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0]     quo_o
);

    logic [DIV_WIDTH:0] shifted;
    logic               ge;

    // The extra top bit keeps the compare exact; after a subtraction the
    // result is always below the divisor, so it fits back into DIV_WIDTH bits.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        ge      = (shifted >= {1'b0, divisor_i});
        rem_o   = ge ? DIV_WIDTH'(shifted - {1'b0, divisor_i}) : shifted[DIV_WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider producing one quotient bit per clock,
// with registered results held until the next accepted start.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0]     quotient_o,
    output logic [DIV_WIDTH-1:0] remainder_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 div_zero_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
    logic                 zero_pend_q, zero_pend_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic [DIV_WIDTH-1:0] step_rem;
    logic [WIDTH-1:0]     step_quo;
    logic                 accept;

    div_step #(
        .WIDTH     (WIDTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // A zero divisor enters DONE with zero_pend set; the results and the done
    // pulse are published one edge later, and start is ignored in that cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        zero_pend_d = zero_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;

        accept = start_i && ((state_q == IDLE) || ((state_q == DONE) && !zero_pend_q));

        case (state_q)
            IDLE: ;
            BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quotient_d  = step_quo;
                    remainder_d = step_rem;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (zero_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q[DIV_WIDTH-1:0];
                    div_zero_d  = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    zero_pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            quo_d      = dividend_i;
            divisor_d  = divisor_i;
            rem_d      = '0;
            cnt_d      = CNT_W'(WIDTH - 1);
            div_zero_d = 1'b0;
            busy_d     = 1'b1;
            if (divisor_i == '0) begin
                state_d     = DONE;
                zero_pend_d = 1'b1;
            end else begin
                state_d = BUSY;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            zero_pend_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            zero_pend_q <= zero_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic
// reference model (integer / and %).
module tb_seq_divider;

    localparam int W  = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic [W-1:0]  quotient;
    logic [DW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          divZero;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  prevQ = '0;
    logic [DW-1:0] prevR = '0;

    seq_divider #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .busy_o      (busy),
        .done_o      (done),
        .div_zero_o  (divZero)
    );

    always #5 clk = ~clk;

    // Hard stop so a wedged DUT can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Division by zero returns all ones and the low dividend bits as remainder.
    task automatic refModel(input logic [W-1:0] a, input logic [DW-1:0] b,
                            output logic [W-1:0] q, output logic [DW-1:0] r, output logic z);
        int unsigned ai, bi;
        ai = a;
        bi = b;
        if (bi == 0) begin
            q = '1;
            r = a[DW-1:0];
            z = 1'b1;
        end else begin
            q = W'(ai / bi);
            r = DW'(ai % bi);
            z = 1'b0;
        end
    endtask

    // One full operation: start, scramble inputs, optional ignored start pulses
    // at busy cycles pulseA/pulseB, then latency, hold and result checks.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [DW-1:0] b,
                                 input string tag, input int pulseA, input int pulseB);
        logic [W-1:0]  eq;
        logic [DW-1:0] er;
        logic          ez;
        int            k;
        int            expLat;
        refModel(a, b, eq, er, ez);
        expLat = (b == 0) ? 1 : W;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = DW'($urandom);
        k = 0;
        while (!done && k < W + 4) begin
            checkOutput({tag, "_busy"}, busy, 1);
            checkOutput({tag, "_holdQ"}, quotient, prevQ);
            checkOutput({tag, "_holdR"}, remainder, prevR);
            checkOutput({tag, "_dzClr"}, divZero, 0);
            start = (k == pulseA || k == pulseB) ? 1'b1 : 1'b0;
            if (start) begin
                dividend = W'($urandom);
                divisor  = DW'($urandom_range(1, 255));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
        end
        checkOutput({tag, "_lat"}, k, expLat);
        checkOutput({tag, "_q"}, quotient, eq);
        checkOutput({tag, "_r"}, remainder, er);
        checkOutput({tag, "_dz"}, divZero, ez);
        checkOutput({tag, "_busyEnd"}, busy, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_doneDrop"}, done, 0);
        prevQ = eq;
        prevR = er;
    endtask

    initial begin
        logic [W-1:0]  eq;
        logic [DW-1:0] er;
        logic          ez;
        logic [W-1:0]  ra;
        logic [DW-1:0] rb;
        int            k;
        int            doneSeen;

        #12;
        rst = 1'b0;
        #1;
        checkOutput("rst_q", quotient, 0);
        checkOutput("rst_r", remainder, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_dz", divZero, 0);

        applyStimulus(16'd200, 8'd7, "d200_7", -1, -1);
        applyStimulus(16'd200, 8'd20, "d200_20", -1, -1);
        applyStimulus(16'd65535, 8'd255, "d65535_255", -1, -1);
        applyStimulus(16'd5, 8'd10, "d5_10", -1, -1);
        applyStimulus(16'd1234, 8'd0, "d1234_0", -1, -1);
        applyStimulus(16'd100, 8'd3, "d100_3", -1, -1);

        // Start pulses while busy must be dropped; only one done follows.
        applyStimulus(16'd1000, 8'd9, "ignore", 3, 9);
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("ignore_extraDone", doneSeen, 0);

        // Back-to-back: start held through DONE is accepted on the edge ending
        // the DONE cycle, so done pulses are WIDTH+1 edges apart.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd300;
        divisor  = 8'd16;
        @(posedge clk);
        #1;
        dividend = 16'd77;
        divisor  = 8'd8;
        k = 0;
        while (!done && k < W + 4) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("b2b_lat1", k, W);
        refModel(16'd300, 8'd16, eq, er, ez);
        checkOutput("b2b_q1", quotient, eq);
        checkOutput("b2b_r1", remainder, er);
        prevQ = eq;
        prevR = er;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                start = 1'b0;
                checkOutput("b2b_doneDrop", done, 0);
                checkOutput("b2b_busy2", busy, 1);
                checkOutput("b2b_holdQ", quotient, prevQ);
            end
        end while (!done && k < W + 4);
        checkOutput("b2b_gap", k, W + 1);
        refModel(16'd77, 8'd8, eq, er, ez);
        checkOutput("b2b_q2", quotient, eq);
        checkOutput("b2b_r2", remainder, er);
        prevQ = eq;
        prevR = er;
        @(posedge clk);
        #1;
        checkOutput("b2b_doneEnd", done, 0);

        // Asynchronous reset between edges aborts the operation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd40000;
        divisor  = 8'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_q", quotient, 0);
        checkOutput("arst_r", remainder, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_dz", divZero, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("arst_noDone", doneSeen, 0);
        prevQ = '0;
        prevR = '0;
        applyStimulus(16'd50, 8'd5, "d50_5", -1, -1);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            if (i % 3 == 0) ra = W'($urandom_range(0, 300));
            rb = (i % 7 == 3) ? 8'd0 : DW'($urandom_range(1, 255));
            applyStimulus(ra, rb, $sformatf("rnd%0d", i), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
